bcd_stopwatch: RTL
==================

Name: bcd_stopwatch

Overview:
- Counts centiseconds as a 4-digit BCD stopwatch (SS.hh, 00.00–99.99) controlled by two push-buttons.
- Sits directly upstream of the 4-digit seven-segment scan driver. Its 16-bit x output feeds the driver's x input, one BCD nibble per digit.
- Contains button synchronisers and debouncers, a tick prescaler, a run-control FSM and a cascaded BCD counter.

Parameters:
- TICK_DIV, 1_000_000: clk cycles per count tick. The default gives 100 Hz from the 100 MHz board clock.
- DB_CYCLES, 2_000_000: consecutive stable cycles required to accept a button level change. The default is 20 ms.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- btn_ss  in  1  raw start/stop button, asynchronous, active-high
- btn_clr  in  1  raw clear button, asynchronous, active-high
- x  out  16  BCD digits: x[15:12] tens of seconds, x[11:8] seconds, x[7:4] tenths, x[3:0] hundredths
- running  out  1  high while the FSM is in RUN
- wrap  out  1  one-cycle pulse when the count rolls over from 99.99 to 00.00

Behaviour:
- Reset (rst_n low, asynchronous; release is synchronous to clk):
  - x=16'h0000, running=0, wrap=0.
  - FSM=IDLE; prescaler, debounce counters and synchronisers all cleared.
- Input conditioning, per button:
  - 2-FF synchroniser feeds a debouncer.
  - Debounced level db updates when the synchronised input has differed from db for DB_CYCLES consecutive cycles.
  - Any sample equal to db resets the counter.
  - A rising edge of db produces a one-cycle pulse (ss_p or clr_p) on the following cycle.
  - Falling edges produce nothing.
  - Latency from raw edge to pulse is 2 + DB_CYCLES + 1 cycles, ±1.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: ss_p goes to RUN.
  - RUN: ss_p goes to PAUSE.
  - PAUSE: ss_p goes to RUN.
  - clr_p in any state goes to IDLE and zeroes the count and prescaler on the next edge.
  - clr_p and ss_p in the same cycle: clear wins, next state IDLE.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; tick=1 on the cycle the count equals TICK_DIV-1, then it wraps to 0.
  - Holds its value in PAUSE, so a partial tick is preserved.
  - Forced to 0 in IDLE.
- BCD counter, advancing on tick:
  - Hundredths 0–9, tenths 0–9, seconds 0–9, tens 0–9, each carrying into the next digit.
  - Every nibble is always in 0–9; no binary-to-BCD conversion is used.
  - 99.99 + tick gives 00.00 and wrap=1 for exactly that cycle. The FSM stays in RUN.
- x is registered and updates on the clk edge where the tick is consumed. It is stable between ticks and in PAUSE/IDLE.
- running is registered and equals (state==RUN).
- Raw button glitches shorter than DB_CYCLES never change state.

Test Plan (TICK_DIV=4, DB_CYCLES=8 for simulation):
- Reset: hold rst_n=0 mid-run, then release → x=16'h0000, running=0, wrap=0 immediately on assertion with no clock edge needed. Count stays 0 until a start.
- Debounce: btn_ss high for 5 cycles, then low → no pulse, running stays 0. btn_ss high for 20 cycles → running=1 within 2+8+2 cycles of the rising edge.
- Counting: start, run 40 cycles → exactly 10 ticks, x=16'h0010. Check the digit carry after 10 ticks (x goes from 0009 to 0010) and the BCD carry at 0099→0100 after 100 ticks.
- Pause/resume:
  - Start, run 6 cycles (1 tick, prescaler at 2), then press ss → x=16'h0001 held for 100 cycles.
  - Press ss again → next tick arrives 2 cycles after the RUN entry (preserved prescaler).
- Wrap: preload by running 9999 ticks → x=16'h9999; the next tick gives x=16'h0000 with wrap high for exactly 1 cycle and running still 1.
- Simultaneous buttons: press ss and clr with identical stimulus while in RUN with x=16'h0123 → state IDLE, x=16'h0000, running=0. Clear in PAUSE also gives x=16'h0000.

Source files
------------

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: 00.00-99.99 centisecond BCD stopwatch driven by debounced start/stop and clear buttons.
module bcd_stopwatch #(
  parameter int TICK_DIV  = 1_000_000,
  parameter int DB_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_ss,
  input  logic        btn_clr,
  output logic [15:0] x,
  output logic        running,
  output logic        wrap
);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam logic [DW-1:0] DB_MAX   = DW'(DB_CYCLES - 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t        r_state, w_next;
  logic [1:0]    w_btn, r_s1, r_s2, r_db, r_dbd, w_p;
  logic [DW-1:0] r_cnt [2];
  logic [TW-1:0] r_pre;
  logic [15:0]   r_x, w_x;
  logic [4:0]    w_c;
  logic          w_tick, w_run, r_running, r_wrap;
  assign w_btn   = {btn_clr, btn_ss};
  assign w_p     = r_db & ~r_dbd;
  assign x       = r_x;
  assign running = r_running;
  assign wrap    = r_wrap;
  // bit 0 is start/stop, bit 1 is clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_db     <= '0;
      r_dbd    <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_s1  <= w_btn;
      r_s2  <= r_s1;
      r_dbd <= r_db;
      for (int i = 0; i < 2; i++)
        if (r_s2[i] == r_db[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == DB_MAX) begin
          r_cnt[i] <= '0;
          r_db[i]  <= r_s2[i];
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = w_p[1] ? IDLE : !w_p[0] ? r_state : (r_state == RUN) ? PAUSE : RUN;
  always_comb
    w_run = (w_next == RUN);
  assign w_tick = (r_state == RUN) && (r_pre == TICK_MAX);
  assign w_c[0] = 1'b1;
  for (genvar d = 0; d < 4; d++) begin : g_dig
    assign w_c[d+1]     = w_c[d] && (r_x[4*d +: 4] == 4'd9);
    assign w_x[4*d +: 4] = !w_c[d] ? r_x[4*d +: 4] :
                           (r_x[4*d +: 4] == 4'd9) ? 4'd0 : r_x[4*d +: 4] + 4'd1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pre     <= '0;
      r_x       <= '0;
      r_wrap    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_running <= w_run;
      r_wrap    <= !w_p[1] && w_tick && w_c[4];
      if (w_p[1]) begin
        r_pre <= '0;
        r_x   <= '0;
      end else if (r_state == IDLE) r_pre <= '0;
      else if (r_state == RUN) begin
        r_pre <= w_tick ? '0 : r_pre + 1'b1;
        if (w_tick) r_x <= w_x;
      end
    end
endmodule
